// File: rtl/mem_req_ctrl.sv
// Requester-side controller for a dual-port word memory: fetches read through port 2,
// data loads/stores go through port 1, and each channel returns its response on a held channel.
module mem_req_ctrl #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 f_req_valid,
  output logic                 f_req_ready,
  input  logic [ADDR_SIZE-1:0] f_req_addr,
  output logic                 f_rsp_valid,
  input  logic                 f_rsp_ready,
  output logic [WORD_SIZE-1:0] f_rsp_data,
  input  logic                 d_req_valid,
  output logic                 d_req_ready,
  input  logic                 d_req_we,
  input  logic [ADDR_SIZE-1:0] d_req_addr,
  input  logic [WORD_SIZE-1:0] d_req_wdata,
  output logic                 d_rsp_valid,
  input  logic                 d_rsp_ready,
  output logic [WORD_SIZE-1:0] d_rsp_data,
  output logic                 mem_r_en1,
  output logic                 mem_w_en,
  output logic [ADDR_SIZE-1:0] mem_addr1,
  output logic [WORD_SIZE-1:0] mem_w_data,
  input  logic [WORD_SIZE-1:0] mem_r_data1,
  output logic                 mem_r_en2,
  output logic [ADDR_SIZE-1:0] mem_addr2,
  input  logic [WORD_SIZE-1:0] mem_r_data2
);

  // Handshake: a request transfers on any rising clk edge where valid and ready are both high;
  // a response transfers where rsp_valid and rsp_ready are both high, and rsp_data is held until then.
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                 f_state;
  state_t                 d_state;
  logic                   f_hs;
  logic                   d_hs;
  logic                   hazard;
  logic                   d_we_q;
  logic [WORD_SIZE-1:0]   d_wdata_q;

  assign d_req_ready = ~reset & ((d_state == IDLE) | ((d_state == RESP) & d_rsp_ready));
  assign d_hs        = d_req_valid & d_req_ready;

  // A fetch racing a store to the same word waits one cycle so it reads only the new value.
  assign hazard      = d_hs & d_req_we & f_req_valid & (f_req_addr == d_req_addr);

  assign f_req_ready = ~reset & ((f_state == IDLE) | ((f_state == RESP) & f_rsp_ready)) & ~hazard;
  assign f_hs        = f_req_valid & f_req_ready;

  assign mem_r_en2   = f_hs;
  assign mem_addr2   = f_req_addr;
  assign mem_r_en1   = d_hs & ~d_req_we;
  assign mem_w_en    = d_hs & d_req_we;
  assign mem_addr1   = d_req_addr;
  assign mem_w_data  = d_req_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      f_state     <= IDLE;
      f_rsp_valid <= 1'b0;
      f_rsp_data  <= '0;
    end else begin
      case (f_state)
        IDLE: if (f_hs) f_state <= WAIT;
        WAIT: begin
          f_state     <= RESP;
          f_rsp_valid <= 1'b1;
          f_rsp_data  <= mem_r_data2;
        end
        RESP: if (f_rsp_ready) begin
          f_rsp_valid <= 1'b0;
          f_state     <= f_hs ? WAIT : IDLE;
        end
        default: begin
          f_state     <= IDLE;
          f_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_state     <= IDLE;
      d_rsp_valid <= 1'b0;
      d_rsp_data  <= '0;
      d_we_q      <= 1'b0;
      d_wdata_q   <= '0;
    end else begin
      if (d_hs) begin
        d_we_q    <= d_req_we;
        d_wdata_q <= d_req_wdata;
      end
      case (d_state)
        IDLE: if (d_hs) d_state <= WAIT;
        WAIT: begin
          d_state     <= RESP;
          d_rsp_valid <= 1'b1;
          // Stores acknowledge with the word they wrote.
          d_rsp_data  <= d_we_q ? d_wdata_q : mem_r_data1;
        end
        RESP: if (d_rsp_ready) begin
          d_rsp_valid <= 1'b0;
          d_state     <= d_hs ? WAIT : IDLE;
        end
        default: begin
          d_state     <= IDLE;
          d_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl: behavioural dual-port memory, a queue-based reference model
// checked every cycle, directed scenarios and a randomized traffic run.
module tb_mem_req_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req_valid, f_req_ready, f_rsp_valid, f_rsp_ready;
  logic [15:0] f_req_addr, f_rsp_data;
  logic        d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_ready;
  logic [15:0] d_req_addr, d_req_wdata, d_rsp_data;
  logic        mem_r_en1, mem_w_en, mem_r_en2;
  logic [15:0] mem_addr1, mem_w_data, mem_r_data1, mem_addr2, mem_r_data2;

  logic        init_en, pl_en;
  logic [5:0]  pl_addr;
  logic [15:0] pl_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] mem [0:63];
  logic [15:0] ref_mem [0:63];
  logic [15:0] f_exp_q[$];
  logic [15:0] d_exp_q[$];
  int          f_cyc_q[$];
  int          d_cyc_q[$];

  always #5 clk = ~clk;

  mem_req_ctrl #(.WORD_SIZE(16), .ADDR_SIZE(16)) dut (
    .clk(clk), .reset(reset),
    .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_req_addr(f_req_addr),
    .f_rsp_valid(f_rsp_valid), .f_rsp_ready(f_rsp_ready), .f_rsp_data(f_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_data(d_rsp_data),
    .mem_r_en1(mem_r_en1), .mem_w_en(mem_w_en), .mem_addr1(mem_addr1),
    .mem_w_data(mem_w_data), .mem_r_data1(mem_r_data1),
    .mem_r_en2(mem_r_en2), .mem_addr2(mem_addr2), .mem_r_data2(mem_r_data2)
  );

  function automatic logic [15:0] init_val(int i);
    logic [15:0] v;
    v = 16'(i);
    return {v[7:0], v[7:0]} ^ 16'hA500;
  endfunction

  // Memory with registered reads; a same-edge read sees the old word.
  always @(posedge clk) begin
    if (init_en) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
    end else if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (mem_w_en) begin
      mem[mem_addr1[5:0]] <= mem_w_data;
    end
    if (mem_r_en1) mem_r_data1 <= mem[mem_addr1[5:0]];
    if (mem_r_en2) mem_r_data2 <= mem[mem_addr2[5:0]];
  end

  // Reference model: one outstanding request per channel, response visible two cycles after
  // acceptance and until consumed; stores update the model memory before a concurrent fetch reads it.
  always @(negedge clk) begin
    logic f_vis, d_vis, f_rdy_exp, d_rdy_exp, st_hs, haz, f_hs_exp, d_hs_exp;
    cyc++;
    if (init_en) for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    if (pl_en) ref_mem[pl_addr] = pl_data;
    if (reset) begin
      checks++;
      if (f_req_ready !== 1'b0 || d_req_ready !== 1'b0 || mem_r_en1 !== 1'b0 ||
          mem_r_en2 !== 1'b0 || mem_w_en !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: f_rdy=%b d_rdy=%b r1=%b r2=%b w=%b required all 0",
                 f_req_ready, d_req_ready, mem_r_en1, mem_r_en2, mem_w_en);
      end
      f_exp_q.delete(); f_cyc_q.delete(); d_exp_q.delete(); d_cyc_q.delete();
    end else begin
      f_vis = (f_exp_q.size() > 0) && (cyc >= f_cyc_q[0] + 2);
      d_vis = (d_exp_q.size() > 0) && (cyc >= d_cyc_q[0] + 2);
      checks++;
      if (f_rsp_valid !== f_vis) begin
        errors++; $display("FAIL f_rsp_valid: got %b required %b at cycle %0d", f_rsp_valid, f_vis, cyc);
      end
      checks++;
      if (d_rsp_valid !== d_vis) begin
        errors++; $display("FAIL d_rsp_valid: got %b required %b at cycle %0d", d_rsp_valid, d_vis, cyc);
      end
      if (f_vis) begin
        checks++;
        if (f_rsp_data !== f_exp_q[0]) begin
          errors++; $display("FAIL f_rsp_data: got %h required %h at cycle %0d", f_rsp_data, f_exp_q[0], cyc);
        end
      end
      if (d_vis) begin
        checks++;
        if (d_rsp_data !== d_exp_q[0]) begin
          errors++; $display("FAIL d_rsp_data: got %h required %h at cycle %0d", d_rsp_data, d_exp_q[0], cyc);
        end
      end
      d_rdy_exp = (d_exp_q.size() == 0) || (d_vis && d_rsp_ready);
      st_hs     = d_req_valid && d_rdy_exp && d_req_we;
      haz       = st_hs && f_req_valid && (f_req_addr == d_req_addr);
      f_rdy_exp = ((f_exp_q.size() == 0) || (f_vis && f_rsp_ready)) && !haz;
      f_hs_exp  = f_req_valid && f_rdy_exp;
      d_hs_exp  = d_req_valid && d_rdy_exp;
      checks++;
      if (f_req_ready !== f_rdy_exp || d_req_ready !== d_rdy_exp) begin
        errors++;
        $display("FAIL req_ready: got f=%b d=%b required f=%b d=%b at cycle %0d",
                 f_req_ready, d_req_ready, f_rdy_exp, d_rdy_exp, cyc);
      end
      checks++;
      if (mem_r_en2 !== f_hs_exp || mem_r_en1 !== (d_hs_exp && !d_req_we) ||
          mem_w_en !== (d_hs_exp && d_req_we)) begin
        errors++;
        $display("FAIL mem_enables: got r2=%b r1=%b w=%b required r2=%b r1=%b w=%b at cycle %0d",
                 mem_r_en2, mem_r_en1, mem_w_en, f_hs_exp, d_hs_exp && !d_req_we,
                 d_hs_exp && d_req_we, cyc);
      end
      checks++;
      if (mem_r_en1 && mem_w_en) begin
        errors++; $display("FAIL port1_exclusive: got r1=1 w=1 required not both at cycle %0d", cyc);
      end
      if (f_hs_exp) begin
        checks++;
        if (mem_addr2 !== f_req_addr) begin
          errors++; $display("FAIL mem_addr2: got %h required %h", mem_addr2, f_req_addr);
        end
      end
      if (d_hs_exp) begin
        checks++;
        if (mem_addr1 !== d_req_addr || (d_req_we && mem_w_data !== d_req_wdata)) begin
          errors++;
          $display("FAIL port1_issue: got addr=%h wdata=%h required addr=%h wdata=%h",
                   mem_addr1, mem_w_data, d_req_addr, d_req_wdata);
        end
      end
      if (f_vis && f_rsp_ready) begin void'(f_exp_q.pop_front()); void'(f_cyc_q.pop_front()); end
      if (d_vis && d_rsp_ready) begin void'(d_exp_q.pop_front()); void'(d_cyc_q.pop_front()); end
      if (d_hs_exp) begin
        if (d_req_we) begin
          ref_mem[d_req_addr[5:0]] = d_req_wdata;
          d_exp_q.push_back(d_req_wdata);
        end else begin
          d_exp_q.push_back(ref_mem[d_req_addr[5:0]]);
        end
        d_cyc_q.push_back(cyc);
      end
      if (f_hs_exp) begin
        f_exp_q.push_back(ref_mem[f_req_addr[5:0]]);
        f_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [5:0] a, input logic [15:0] v);
    pl_en = 1'b1; pl_addr = a; pl_data = v;
    tick;
    pl_en = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; init_en = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    init_en = 1'b0;
    @(negedge clk);
    checks++;
    if (f_rsp_valid !== 1'b0 || d_rsp_valid !== 1'b0 || f_rsp_data !== 16'h0 || d_rsp_data !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: got fv=%b dv=%b fd=%h dd=%h required 0 0 0000 0000",
               f_rsp_valid, d_rsp_valid, f_rsp_data, d_rsp_data);
    end
    tick; reset = 1'b0;
    @(negedge clk);
    checks++;
    if (f_req_ready !== 1'b1 || d_req_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_reset: got f=%b d=%b required 1 1", f_req_ready, d_req_ready);
    end
  endtask

  task automatic test_store_load;
    tick;
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 16'h0010; d_req_wdata = 16'hBEEF;
    @(negedge clk);
    checks++;
    if (d_req_ready !== 1'b1 || mem_w_en !== 1'b1 || mem_r_en1 !== 1'b0) begin
      errors++; $display("FAIL store_issue: got rdy=%b w=%b r1=%b required 1 1 0", d_req_ready, mem_w_en, mem_r_en1);
    end
    tick; d_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (d_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL store_early_rsp: got %b required 0", d_rsp_valid);
    end
    tick; d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 16'h0010;
    @(negedge clk);
    checks++;
    if (d_rsp_valid !== 1'b1 || d_rsp_data !== 16'hBEEF || d_req_ready !== 1'b1 || mem_r_en1 !== 1'b1) begin
      errors++;
      $display("FAIL store_ack: got v=%b data=%h rdy=%b r1=%b required 1 beef 1 1",
               d_rsp_valid, d_rsp_data, d_req_ready, mem_r_en1);
    end
    tick; d_req_valid = 1'b0;
    tick;
    @(negedge clk);
    checks++;
    if (d_rsp_valid !== 1'b1 || d_rsp_data !== 16'hBEEF) begin
      errors++; $display("FAIL load_after_store: got v=%b data=%h required 1 beef", d_rsp_valid, d_rsp_data);
    end
    tick;
  endtask

  task automatic test_concurrent;
    int n1 = 0;
    int n2 = 0;
    preload(6'h04, 16'h1234);
    preload(6'h08, 16'h5678);
    f_req_valid = 1'b1; f_req_addr = 16'h0004;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 16'h0008;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n1 += int'(mem_r_en1); n2 += int'(mem_r_en2);
      if (i == 2) begin
        checks++;
        if (f_rsp_valid !== 1'b1 || f_rsp_data !== 16'h1234 || d_rsp_valid !== 1'b1 || d_rsp_data !== 16'h5678) begin
          errors++;
          $display("FAIL concurrent_rsp: got fv=%b fd=%h dv=%b dd=%h required 1 1234 1 5678",
                   f_rsp_valid, f_rsp_data, d_rsp_valid, d_rsp_data);
        end
      end
      tick;
      f_req_valid = 1'b0; d_req_valid = 1'b0;
    end
    checks++;
    if (n1 != 1 || n2 != 1) begin
      errors++; $display("FAIL concurrent_pulses: got r1=%0d r2=%0d required 1 1", n1, n2);
    end
  endtask

  task automatic test_backpressure;
    preload(6'h20, 16'h00AA);
    d_rsp_ready = 1'b0;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 16'h0020;
    tick; d_req_addr = 16'h0021;
    @(negedge clk);
    checks++;
    if (d_req_ready !== 1'b0 || d_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL bp_wait: got rdy=%b v=%b required 0 0", d_req_ready, d_rsp_valid);
    end
    for (int i = 0; i < 5; i++) begin
      tick;
      @(negedge clk);
      checks++;
      if (d_rsp_valid !== 1'b1 || d_rsp_data !== 16'h00AA || d_req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: got v=%b data=%h rdy=%b required 1 00aa 0", d_rsp_valid, d_rsp_data, d_req_ready);
      end
    end
    tick; d_rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (d_req_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: got rdy=%b required 1", d_req_ready);
    end
    tick; d_req_valid = 1'b0;
    repeat (3) tick;
  endtask

  task automatic test_hazard;
    preload(6'h30, 16'h1111);
    f_req_valid = 1'b1; f_req_addr = 16'h0030;
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 16'h0030; d_req_wdata = 16'h7777;
    @(negedge clk);
    checks++;
    if (f_req_ready !== 1'b0 || d_req_ready !== 1'b1 || mem_r_en2 !== 1'b0 || mem_w_en !== 1'b1) begin
      errors++;
      $display("FAIL hazard_stall: got frdy=%b drdy=%b r2=%b w=%b required 0 1 0 1",
               f_req_ready, d_req_ready, mem_r_en2, mem_w_en);
    end
    tick; d_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (f_req_ready !== 1'b1 || mem_r_en2 !== 1'b1) begin
      errors++; $display("FAIL hazard_retry: got frdy=%b r2=%b required 1 1", f_req_ready, mem_r_en2);
    end
    tick; f_req_valid = 1'b0;
    tick;
    @(negedge clk);
    checks++;
    if (f_rsp_valid !== 1'b1 || f_rsp_data !== 16'h7777) begin
      errors++; $display("FAIL hazard_data: got v=%b data=%h required 1 7777", f_rsp_valid, f_rsp_data);
    end
    repeat (2) tick;
  endtask

  task automatic test_back_to_back;
    int acc[4];
    int w;
    f_req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      f_req_addr = 16'(i);
      w = 0;
      @(negedge clk);
      while (f_req_ready !== 1'b1 && w < 8) begin
        tick; @(negedge clk); w++;
      end
      checks++;
      if (w >= 8) begin
        errors++; $display("FAIL stream_timeout: got no accept for fetch %0d required accept within 8 cycles", i);
      end
      acc[i] = cyc;
      if (i > 0) begin
        checks++;
        if (acc[i] - acc[i-1] != 2 || f_rsp_data !== init_val(i - 1)) begin
          errors++;
          $display("FAIL stream_%0d: got gap=%0d data=%h required gap=2 data=%h",
                   i, acc[i] - acc[i-1], f_rsp_data, init_val(i - 1));
        end
      end
      tick;
    end
    f_req_valid = 1'b0;
    repeat (3) tick;
  endtask

  task automatic test_reset_mid;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 16'h0005;
    @(negedge clk);
    checks++;
    if (d_req_ready !== 1'b1) begin
      errors++; $display("FAIL abort_issue: got rdy=%b required 1", d_req_ready);
    end
    tick; d_req_valid = 1'b0; reset = 1'b1;
    tick; reset = 1'b0;
    @(negedge clk);
    checks++;
    if (d_rsp_valid !== 1'b0 || d_rsp_data !== 16'h0 || d_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_state: got v=%b data=%h rdy=%b required 0 0000 1", d_rsp_valid, d_rsp_data, d_req_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick; @(negedge clk);
      checks++;
      if (d_rsp_valid !== 1'b0) begin
        errors++; $display("FAIL abort_no_rsp: got v=%b required 0", d_rsp_valid);
      end
    end
  endtask

  task automatic test_random;
    logic fh, dh;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      fh = f_req_valid & f_req_ready;
      dh = d_req_valid & d_req_ready;
      tick;
      if (!f_req_valid || fh) begin
        f_req_valid = 1'($urandom_range(0, 1));
        f_req_addr  = 16'($urandom_range(0, 15));
      end
      if (!d_req_valid || dh) begin
        d_req_valid = 1'($urandom_range(0, 1));
        d_req_we    = 1'($urandom_range(0, 1));
        d_req_addr  = 16'($urandom_range(0, 15));
        d_req_wdata = 16'($urandom);
      end
      f_rsp_ready = ($urandom_range(0, 3) != 0);
      d_rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    fh = f_req_valid & f_req_ready;
    dh = d_req_valid & d_req_ready;
    tick;
    f_req_valid = 1'b0; d_req_valid = 1'b0;
    f_rsp_ready = 1'b1; d_rsp_ready = 1'b1;
    repeat (6) tick;
    @(negedge clk);
    checks++;
    if (f_exp_q.size() != 0 || d_exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d fetch and %0d data responses outstanding required 0 0",
               f_exp_q.size(), d_exp_q.size());
    end
  endtask

  initial begin
    reset = 1'b1; init_en = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    f_req_valid = 1'b0; f_req_addr = '0; f_rsp_ready = 1'b1;
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = '0; d_req_wdata = '0; d_rsp_ready = 1'b1;
    test_reset;
    test_store_load;
    test_concurrent;
    test_backpressure;
    test_hazard;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_req_ctrl.md
Name: mem_req_ctrl

Overview:
- Requester-side controller for the CPU's dual-port word memory.
- Accepts instruction-fetch requests and data load/store requests on valid/ready channels and drives the memory's read/write enables and addresses.
- Captures the memory's registered read data and returns it on held response channels.
- Fetch traffic uses memory port 2 (read-only); data traffic uses memory port 1 (read or write).

Parameters:
WORD_SIZE, 16, data word width in bits
ADDR_SIZE, 16, address width in bits

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
f_req_valid  in  1  fetch request valid
f_req_ready  out  1  fetch request accepted this cycle when valid&ready
f_req_addr  in  ADDR_SIZE  fetch address
f_rsp_valid  out  1  fetch response valid, held until f_rsp_ready
f_rsp_ready  in  1  fetch response consumed
f_rsp_data  out  WORD_SIZE  fetched word
d_req_valid  in  1  data request valid
d_req_ready  out  1  data request accepted
d_req_we  in  1  1=store, 0=load
d_req_addr  in  ADDR_SIZE  data address
d_req_wdata  in  WORD_SIZE  store data
d_rsp_valid  out  1  data response valid, held until d_rsp_ready
d_rsp_ready  in  1  data response consumed
d_rsp_data  out  WORD_SIZE  load data; for stores, the stored word
mem_r_en1  out  1  memory port-1 read enable
mem_w_en  out  1  memory port-1 write enable
mem_addr1  out  ADDR_SIZE  memory port-1 address
mem_w_data  out  WORD_SIZE  memory write data
mem_r_data1  in  WORD_SIZE  memory port-1 registered read data
mem_r_en2  out  1  memory port-2 read enable
mem_addr2  out  ADDR_SIZE  memory port-2 address
mem_r_data2  in  WORD_SIZE  memory port-2 registered read data

Behaviour:
- Memory contract: a read issued at edge N has data valid on mem_r_dataX during cycle N+1. mem_r_en1 and mem_w_en must never be high together.
- Each channel has an independent FSM with states IDLE, WAIT, RESP, and at most one outstanding request.
- Issue: a handshake occurs when valid&ready are both high.
  - Issue outputs are combinational from the handshake:
    - Fetch: mem_r_en2 = f_req_valid&f_req_ready; mem_addr2 = f_req_addr.
    - Data load: mem_r_en1 = d_req_valid&d_req_ready&~d_req_we.
    - Data store: mem_w_en = d_req_valid&d_req_ready&d_req_we; mem_w_data = d_req_wdata.
    - mem_addr1 = d_req_addr.
  - When no handshake occurs, all enables are 0. Addresses and data are don't-care while enables are low.
- Transitions:
  - IDLE->WAIT on handshake.
  - WAIT->RESP unconditionally; the rsp data register captures mem_r_dataX (loads/fetch) or the latched store word (stores).
  - RESP->IDLE on rsp_ready with no new handshake.
  - RESP->WAIT on rsp_ready with a new handshake in the same cycle.
- Ready:
  - f_req_ready = (state==IDLE | (state==RESP & f_rsp_ready)) & ~hazard.
  - d_req_ready = state==IDLE | (state==RESP & d_rsp_ready).
  - Both ready outputs are 0 while reset is high.
- Latency: a response is valid 2 cycles after the request handshake. Peak throughput is 1 request per 2 cycles per channel with rsp_ready tied high.
- Response hold: rsp_valid=1 in RESP only. rsp_data stays stable while valid and not ready.
- Hazard: hazard = data store handshake this cycle & f_req_valid & f_req_addr==d_req_addr. When hazard is high, the fetch is stalled one cycle, so a fetch always sees either fully-old or fully-new data, never same-edge ambiguity. A load to the same address as a concurrent fetch is not a hazard.
- Channels are otherwise fully independent; simultaneous fetch and data issue is allowed.
- Address and data widths are passed through unchanged; no wrap or arithmetic.
- Reset (synchronous, any state, including WAIT/RESP mid-operation):
  - Both FSMs go to IDLE.
  - f_rsp_valid=0, d_rsp_valid=0, f_rsp_data=0, d_rsp_data=0.
  - All mem enables are 0 during the reset cycle.
  - In-flight responses are discarded; memory writes already issued are not undone.

Test Plan:
- Store then load: d store addr=0x0010 data=0xBEEF, then load 0x0010 -> store ack d_rsp_data=0xBEEF 2 cycles after accept; load returns 0xBEEF 2 cycles after its accept; mem_r_en1 never high with mem_w_en.
- Concurrent traffic: fetch 0x0004 (mem preloaded 0x1234) and load 0x0008 (preloaded 0x5678) in the same cycle -> both rsp_valid 2 cycles later with 0x1234 and 0x5678; mem_r_en2 and mem_r_en1 pulse once each.
- Backpressure: load 0x0020 (=0x00AA) with d_rsp_ready=0 for 5 cycles -> d_rsp_valid and data 0x00AA held stable; d_req_ready=0 throughout; d_req_ready rises in the cycle d_rsp_ready=1.
- Hazard: fetch 0x0030 and store 0x0030 data=0x7777 presented together (old value 0x1111) -> f_req_ready=0 that cycle; fetch issues next cycle and returns 0x7777.
- Streaming: 4 back-to-back fetches 0x0000..0x0003 with rsp_ready=1 -> accepts every 2nd cycle, responses in order.
- Reset mid-op: assert reset during WAIT of a load -> next cycle d_rsp_valid=0, d_rsp_data=0, FSM IDLE, d_req_ready=1 after reset drops; no response for the aborted load.
